// File: rtl/alu2_ctrl_pkg.sv
// Shared types for the ALU request arbiter: opcodes, FSM states, operand-owner encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu2_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_GT   = 4'hD;
    localparam logic [3:0] OP_LT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef logic [IDX_W-1:0] idx_t;
    // Top bit set marks "nobody owns the ALU's held operands".
    typedef logic [IDX_W:0]   owner_t;
    localparam owner_t OWNER_NONE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over the request vector, search starts just after last_grant.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter
    import alu2_ctrl_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  idx_t             last_grant,
    output logic [N_REQ-1:0] grant,
    output idx_t             grant_idx,
    output logic             grant_vld
);

    int               cand;
    logic [N_REQ-1:0] req_sh;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        cand      = 0;
        req_sh    = '0;
        grant     = '0;
        grant_idx = last_grant;
        grant_vld = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand   = (int'(last_grant) + off) % N_REQ;
            req_sh = req >> cand;
            if (req_sh[0]) begin
                grant_idx = idx_t'(cand);
                grant_vld = 1'b1;
                grant     = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/alu2_arbiter.sv
// Shares one registered ALU between N_REQ requesters, tracking who owns its held operands.
// Latency: accept t, ALU issue t+1, response t+3 (t+2 on divide-by-zero, t+2+TIMEOUT on timeout).
// Backpressure: one request in flight; req_ready pulses only in IDLE, others keep req_valid high.
module alu2_arbiter
    import alu2_ctrl_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    input  logic [4*N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0]   req_new_data,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [15:0]        resp_data,
    output logic               resp_err,
    output logic               busy,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic               alu_data_enable,
    output logic [3:0]         alu_control,
    output logic               alu_control_enable,
    input  logic [15:0]        alu_result,
    input  logic               alu_result_enable
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    idx_t             cur_idx, last_grant, grant_idx;
    logic [3:0]       cur_op;
    logic [7:0]       cur_a, cur_b;
    logic             cur_new;
    owner_t           owner;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       shadow_a [MAX_REQ];
    logic [7:0]       shadow_b [MAX_REQ];

    logic [N_REQ-1:0] grant;
    logic             grant_vld;
    logic [7:0]       sel_a, sel_b, eff_a, eff_b;
    logic [3:0]       sel_op;
    logic             sel_new;
    logic             is_div0, issue_de, timed_out;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    assign sel_a   = req_a[8*grant_idx +: 8];
    assign sel_b   = req_b[8*grant_idx +: 8];
    assign sel_op  = req_op[4*grant_idx +: 4];
    assign sel_new = req_new_data[grant_idx +: 1] == 1'b1;
    assign eff_a   = sel_new ? sel_a : shadow_a[grant_idx];
    assign eff_b   = sel_new ? sel_b : shadow_b[grant_idx];

    assign is_div0   = (cur_op == OP_DIV) && (cur_b == 8'h00);
    // Skip the operand load only when the ALU already holds this requester's operands.
    assign issue_de  = cur_new || (owner != {1'b0, cur_idx});
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt          = state;
        req_ready          = '0;
        resp_valid         = '0;
        alu_a              = '0;
        alu_b              = '0;
        alu_data_enable    = 1'b0;
        alu_control        = '0;
        alu_control_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vld && reset) begin
                    req_ready = grant;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_div0) begin
                    state_nxt = ST_RESP;
                end else begin
                    alu_control_enable = 1'b1;
                    alu_control        = cur_op;
                    alu_a              = cur_a;
                    alu_b              = cur_b;
                    alu_data_enable    = issue_de;
                    state_nxt          = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_result_enable || timed_out) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = N_REQ'(1) << cur_idx;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cur_idx    <= '0;
            cur_op     <= '0;
            cur_a      <= '0;
            cur_b      <= '0;
            cur_new    <= 1'b0;
            owner      <= OWNER_NONE;
            last_grant <= idx_t'(N_REQ - 1);
            wait_cnt   <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < MAX_REQ; i++) begin
                shadow_a[i] <= '0;
                shadow_b[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        cur_idx <= grant_idx;
                        cur_op  <= sel_op;
                        cur_new <= sel_new;
                        cur_a   <= eff_a;
                        cur_b   <= eff_b;
                        if (sel_new) begin
                            shadow_a[grant_idx] <= sel_a;
                            shadow_b[grant_idx] <= sel_b;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    if (is_div0) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else if (issue_de) begin
                        owner <= {1'b0, cur_idx};
                    end
                end
                ST_WAIT: begin
                    if (alu_result_enable) begin
                        resp_data <= alu_result;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        // The ALU state is unknown after a timeout, so force a reload next time.
                        resp_data <= 16'hFFFF;
                        resp_err  <= 1'b1;
                        owner     <= OWNER_NONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: last_grant <= cur_idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu2_arbiter.sv
// Bench for alu2_arbiter: schedule-based reference model plus directed literal checks and random traffic.
module tb_alu2_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [8*N-1:0]  req_a = '0;
    logic [8*N-1:0]  req_b = '0;
    logic [4*N-1:0]  req_op = '0;
    logic [N-1:0]    req_new_data = '0;
    logic [N-1:0]    resp_valid;
    logic [15:0]     resp_data;
    logic            resp_err;
    logic            busy;
    logic [7:0]      alu_a, alu_b;
    logic            alu_data_enable;
    logic [3:0]      alu_control;
    logic            alu_control_enable;
    logic [15:0]     alu_result = '0;
    logic            alu_result_enable = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit alu_mute = 0;
    bit spur_en  = 0;

    alu2_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_a              (req_a),
        .req_b              (req_b),
        .req_op             (req_op),
        .req_new_data       (req_new_data),
        .resp_valid         (resp_valid),
        .resp_data          (resp_data),
        .resp_err           (resp_err),
        .busy               (busy),
        .alu_a              (alu_a),
        .alu_b              (alu_b),
        .alu_data_enable    (alu_data_enable),
        .alu_control        (alu_control),
        .alu_control_enable (alu_control_enable),
        .alu_result         (alu_result),
        .alu_result_enable  (alu_result_enable)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0: return 16'(a) + 16'(b);
            4'h1: return 16'(a) - 16'(b);
            4'h2: return 16'(a) * 16'(b);
            4'h3: return (b == 0) ? 16'h0 : 16'(a / b);
            default: return {op, 4'h0, a ^ b};
        endcase
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            int i = (last + off) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // External ALU: latches operands on data_enable, strobes its result one cycle after control_enable.
    initial begin
        logic ce, de;
        logic [7:0] a, b, ha, hb;
        logic [3:0] op;
        logic bs;
        ha = '0; hb = '0;
        forever begin
            @(negedge clock);
            ce = alu_control_enable; de = alu_data_enable;
            a = alu_a; b = alu_b; op = alu_control; bs = busy;
            @(posedge clock); #1;
            if (ce && de) begin ha = a; hb = b; end
            if (ce && !alu_mute) begin
                alu_result_enable = 1'b1;
                alu_result = alu_fn(op, ha, hb);
            end else if (spur_en && !bs && $urandom_range(3) == 0) begin
                alu_result_enable = 1'b1;
                alu_result = 16'($urandom);
            end else begin
                alu_result_enable = 1'b0;
            end
        end
    end

    // Reference model: one request at a time, outcome and timing derived at accept.
    logic [7:0]  m_sa [N];
    logic [7:0]  m_sb [N];
    int          m_owner, m_last, m_w, acc_t, resp_t;
    bit          inflight;
    logic        m_div0, m_de, m_nd, m_err;
    logic [7:0]  m_a, m_b;
    logic [3:0]  m_op;
    logic [15:0] m_data;
    logic [N-1:0] e_ready, e_resp;
    logic         e_busy;
    logic [21:0]  e_alu;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin m_sa[i] = '0; m_sb[i] = '0; end
            m_owner = -1; m_last = N - 1; inflight = 0;
        end else begin
            e_ready = '0; e_resp = '0; e_busy = 1'b0; e_alu = '0;
            if (inflight) begin
                e_busy = (cyc > acc_t) && (cyc <= resp_t);
                if (cyc == acc_t + 1 && !m_div0) e_alu = {1'b1, m_de, m_op, m_a, m_b};
                if (cyc == resp_t) begin
                    e_resp = N'(1) << m_w;
                    chk("model resp_data", resp_data, m_data);
                    chk("model resp_err", resp_err, m_err);
                    m_last = m_w;
                    inflight = 0;
                end
            end else begin
                m_w = rr_pick(m_last, req_valid);
                if (m_w >= 0) begin
                    e_ready = N'(1) << m_w;
                    inflight = 1; acc_t = cyc;
                    m_nd = req_new_data[m_w];
                    m_op = req_op[4*m_w +: 4];
                    if (m_nd) begin
                        m_sa[m_w] = req_a[8*m_w +: 8];
                        m_sb[m_w] = req_b[8*m_w +: 8];
                    end
                    m_a = m_sa[m_w]; m_b = m_sb[m_w];
                    m_div0 = (m_op == 4'h3) && (m_b == 0);
                    if (m_div0) begin
                        resp_t = cyc + 2; m_data = 16'h0; m_err = 1'b1;
                    end else begin
                        m_de = m_nd || (m_owner != m_w);
                        if (m_de) m_owner = m_w;
                        if (alu_mute) begin
                            resp_t = cyc + 2 + TIMEOUT; m_data = 16'hFFFF; m_err = 1'b1; m_owner = -1;
                        end else begin
                            resp_t = cyc + 3; m_data = alu_fn(m_op, m_a, m_b); m_err = 1'b0;
                        end
                    end
                end
            end
            chk("model req_ready", req_ready, e_ready);
            chk("model resp_valid", resp_valid, e_resp);
            chk("model busy", busy, e_busy);
            chk("model alu", {alu_control_enable, alu_data_enable, alu_control, alu_a, alu_b}, e_alu);
        end
    end

    task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic nd, input logic [15:0] ed, input logic ee, input int elat,
                          input logic check_de, input logic ede, input string nm);
        int t, seen;
        logic ece;
        t = 0; seen = 0;
        ece = (elat != 2);
        @(posedge clock); #1;
        req_a[8*i +: 8] = a; req_b[8*i +: 8] = b; req_op[4*i +: 4] = op;
        req_new_data[i] = nd; req_valid[i] = 1'b1;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clock);
            if (req_ready[i]) begin seen = 1; t = cyc; end
        end
        chk({nm, " accept"}, seen, 1);
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
        @(negedge clock);
        chk({nm, " ctl_en"}, alu_control_enable, ece);
        if (check_de) chk({nm, " data_en"}, alu_data_enable, ede);
        if (ece) chk({nm, " control"}, alu_control, op);
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clock);
            if (resp_valid[i]) begin
                seen = 1;
                chk({nm, " latency"}, cyc - t, elat);
                chk({nm, " data"}, resp_data, ed);
                chk({nm, " err"}, resp_err, ee);
            end
        end
        chk({nm, " resp seen"}, seen, 1);
    endtask

    initial begin
        int t, seen, acc;
        logic [N-1:0] rdy_s, eo;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("reset busy", busy, 0);
        chk("reset resp_data", resp_data, 0);
        chk("reset outputs", {resp_valid, resp_err, alu_control_enable, alu_data_enable, alu_a, alu_b}, 0);

        do_req(0, 8'd5, 8'd3, 4'h0, 1'b1, 16'd8, 1'b0, 3, 1'b1, 1'b1, "r0 add");

        // Reset while the request sits in WAIT: response must vanish.
        @(posedge clock); #1;
        req_a[15:8] = 8'd9; req_b[15:8] = 8'd9; req_op[7:4] = 4'h0; req_new_data[1] = 1'b1; req_valid[1] = 1'b1;
        seen = 0; t = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clock);
            if (req_ready[1]) begin seen = 1; t = cyc; end
        end
        chk("rstwait accept", seen, 1);
        @(posedge clock); #1 req_valid[1] = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rstwait in wait", busy, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("rstwait busy", busy, 0);
        chk("rstwait outputs", {resp_valid, resp_data, resp_err, alu_control_enable, alu_data_enable}, 0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (resp_valid != 0) seen = 1;
        end
        chk("rstwait no resp", seen, 0);

        // Two requesters holding valid: accepts alternate starting at r0.
        @(posedge clock); #1;
        req_a = {8'd3, 8'd1}; req_b = {8'd4, 8'd2}; req_op = {4'h2, 4'h0};
        req_new_data = '1; req_valid = '1;
        acc = 0;
        for (int k = 0; k < 60 && acc < 4; k++) begin
            @(negedge clock);
            if (resp_valid[0]) chk("alt r0 data", resp_data, 16'd3);
            if (resp_valid[1]) chk("alt r1 data", resp_data, 16'd12);
            if (req_ready != 0) begin
                eo = (acc % 2 == 0) ? 2'b01 : 2'b10;
                chk("alt order", req_ready, eo);
                acc++;
            end
        end
        chk("alt accepts", acc, 4);
        @(posedge clock); #1 req_valid = '0;
        repeat (6) @(posedge clock);

        do_req(0, 8'd10, 8'd4, 4'h1, 1'b1, 16'd6,  1'b0, 3, 1'b1, 1'b1, "reuse r0 sub");
        do_req(1, 8'd7,  8'd7, 4'h0, 1'b1, 16'd14, 1'b0, 3, 1'b1, 1'b1, "reuse r1 add");
        do_req(0, 8'd99, 8'd99, 4'h2, 1'b0, 16'd40, 1'b0, 3, 1'b1, 1'b1, "reuse r0 mul");
        do_req(0, 8'd99, 8'd99, 4'h0, 1'b0, 16'd14, 1'b0, 3, 1'b1, 1'b0, "reuse r0 held");
        do_req(1, 8'd9,  8'd0, 4'h3, 1'b1, 16'd0,  1'b1, 2, 1'b0, 1'b0, "div0 r1");

        alu_mute = 1;
        do_req(0, 8'd20, 8'd5, 4'h0, 1'b1, 16'hFFFF, 1'b1, TIMEOUT + 2, 1'b1, 1'b1, "timeout r0");
        alu_mute = 0;
        do_req(0, 8'd0, 8'd0, 4'h1, 1'b0, 16'd15, 1'b0, 3, 1'b1, 1'b1, "after timeout r0");

        // Random traffic with spurious ALU strobes outside WAIT.
        spur_en = 1;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clock);
            rdy_s = req_ready;
            @(posedge clock); #1;
            for (int i = 0; i < N; i++) begin
                if (rdy_s[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
                    req_op[4*i +: 4] = 4'($urandom_range(5));
                    req_new_data[i] = 1'($urandom_range(1));
                    req_valid[i] = 1'b1;
                end
            end
        end
        @(negedge clock);
        rdy_s = req_ready;
        @(posedge clock); #1;
        req_valid = '0;
        spur_en = 0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("drain busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu2_arbiter.md
# alu2_arbiter

Shares one 8-bit ALU datapath (operands A/B, 4-bit opcode, registered 16-bit Result, one-cycle `result_enable` strobe, operand hold when `data_enable`=0) between N_REQ requesters. Accepts one request at a time under round-robin arbitration and sequences the ALU handshake. Returns the 16-bit result with a one-hot response pulse. Tracks which requester owns the ALU's held operands, so operand reuse is correct across requesters.

## Interface
- N_REQ, 2, number of requesters (2..4)
- TIMEOUT, 4, cycles waited in WAIT for `alu_result_enable` before error
- clock  in  1  single clock, posedge
- reset  in  1  synchronous, active-low
- req_valid  in  N_REQ  request pending per requester
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse
- req_a / req_b  in  8*N_REQ  operands, requester i at [8i+7:8i]
- req_op  in  4*N_REQ  opcode, requester i at [4i+3:4i]
- req_new_data  in  N_REQ  1 = use supplied operands; 0 = reuse this requester's last operands
- resp_valid  out  N_REQ  one-hot, one-cycle response pulse
- resp_data  out  16  result, valid with resp_valid
- resp_err  out  1  valid with resp_valid: divide-by-zero or timeout
- busy  out  1  state != IDLE
- alu_a, alu_b  out  8  ALU operands
- alu_data_enable  out  1  ALU latches operands this cycle
- alu_control  out  4  opcode
- alu_control_enable  out  1  ALU computes this cycle
- alu_result  in  16  ALU Result
- alu_result_enable  in  1  ALU result strobe

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, the rr_arbiter picks the winner, starting its search at the index after last_grant.
  - Pulse req_ready[w].
  - Latch op, w and the effective operands. The effective operands are req_a/req_b if req_new_data, otherwise shadow[w].
  - If req_new_data, write the operands to shadow[w].
  - Go to ISSUE.
- ISSUE: if op==4'h3 and effective b==0, skip the ALU: resp_data=0, resp_err=1, go to RESP. Otherwise:
  - Drive alu_control_enable=1, alu_control=op, alu_a/alu_b=effective operands.
  - Drive alu_data_enable=1 unless req_new_data was 0 and owner==w. In that case drive 0, so the ALU uses its held operands.
  - Set owner=w when alu_data_enable=1.
  - Go to WAIT.
- WAIT: when alu_result_enable=1, capture resp_data=alu_result, resp_err=0, go to RESP. After TIMEOUT cycles without it: resp_data=16'hFFFF, resp_err=1, owner=invalid, go to RESP.
- RESP: resp_valid[w]=1 for one cycle, then IDLE. Update last_grant=w.
- ALU outputs are 0 in every state except ISSUE.
- req_valid is ignored outside IDLE. A requester holds its request until req_ready.
- owner starts invalid. With owner invalid, alu_data_enable is always 1.
- A request with req_new_data=0 and no prior write uses shadow reset value 0/0.

## Timing
- Reset (reset=0 at posedge):
  - state=IDLE.
  - All outputs 0, including resp_data.
  - Shadows 0, owner invalid, last_grant=N_REQ-1, so requester 0 wins first.
  - Reset overrides any in-flight operation; a pending response is dropped, with no resp_valid.
- Accept (req_ready) at cycle t. ISSUE at t+1. alu_result_enable expected at t+2. resp_valid at t+3.
- Divide-by-zero path: resp_valid at t+2.
- Throughput: at most one operation per 4 cycles. busy stays high from t+1 through the RESP cycle.
- Simultaneous req_valid: only one accept per IDLE cycle. The loser keeps waiting and wins the next arbitration if still valid.
- Spurious alu_result_enable outside WAIT is ignored.

## Structure
- Package alu2_ctrl_pkg:
  - Opcode constants OP_ADD=4'h0, OP_SUB=4'h1, OP_MUL=4'h2, OP_DIV=4'h3, OP_SHL … OP_EQ=4'hF.
  - State enum.
  - OWNER_NONE encoding.
- Sub-module rr_arbiter:
  - Combinational round-robin pick, inputs req vector and last_grant.
  - Outputs one-hot grant and index.
  - Instantiated once.

## Test plan
- r0: a=5, b=3, op=0, new → req_ready[0] at t. ALU control_enable, data_enable and control=0 at t+1. resp_valid[0] at t+3 with resp_data=8, resp_err=0.
- r0 and r1 valid together, both holding valid: accepts alternate r0, r1, r0, r1. Each response goes to the right requester with the right result.
- Operand reuse:
  - r0 new 10,4 op1 → 6.
  - r1 new 7,7 op0 → 14.
  - r0 reuse op2 → 40, with alu_data_enable=1 (owner was r1).
  - r0 reuse op0 → 14, with alu_data_enable=0.
- r1: a=9, b=0, op=3 → no alu_control_enable. resp_valid[1] at t+2 with resp_data=0, resp_err=1.
- ALU model never strobes alu_result_enable → resp_valid at t+2+TIMEOUT with resp_data=16'hFFFF, resp_err=1. The next reuse request drives alu_data_enable=1.
- reset=0 during WAIT → next cycle busy=0 and all outputs 0. No resp_valid follows. A new request completes normally.
